vin_cfa_sequencer: RTL and testbench
====================================

# vin_cfa_sequencer

Pixel-phase sequencer for the video-input colour path. It tracks frame, line and beat position from the input sync/valid stream and drives per-beat colour-select codes. The colour mixer uses these codes to pick luma (mono panels) or a single R/G/B channel per pixel (DES colour-filter panels). It sits beside the colour mixer and sees the same in_vsync/in_hsync/in_valid stream. It also reports per-frame line and beat statistics and sticky protocol errors.

## Interface
- CNT_W, 12, width of line and beat counters and status outputs
- clk  input  1  pixel-pair clock shared with colour mixer
- rstn  input  1  asynchronous active-low reset
- cfg_mode  input  2  0 = mono, 1 = DES 3-phase, 2/3 = reserved (treated as mono); shadowed at frame start
- cfg_x_offset  input  2  starting pixel phase for first active line (values ≥3 treated as 0); shadowed at frame start
- cfg_y_offset  input  2  line-phase increment per active line (values ≥3 treated as 1); shadowed at frame start
- in_vsync  input  1  vertical sync, level
- in_hsync  input  1  horizontal sync, rising edge marks line start
- in_valid  input  1  one beat = even + odd pixel
- out_sel_even  output  2  channel for even pixel of current beat: 0 = R, 1 = G, 2 = B, 3 = luma
- out_sel_odd  output  2  channel for odd pixel, same encoding
- out_frame_start  output  1  one-cycle pulse on frame start
- out_lines  output  CNT_W  active-line count of the last completed frame
- out_beats  output  CNT_W  beat count of the last active line
- out_err  output  1  sticky: in_valid coincided with an hsync rising edge; cleared only by reset

## Operation
- hs_last register; line edge = in_hsync & ~hs_last.
- Frame start = line edge with in_vsync high:
  - shadow cfg_*
  - line_phase ← x_offset
  - pix_phase ← x_offset
  - out_lines ← line_cnt (saturated); line_cnt ← 0
  - line_had_data ← 0
  - pulse out_frame_start
- Line edge with in_vsync low:
  - if line_had_data:
    - line_phase ← (line_phase + y_inc) mod 3
    - pix_phase ← the new line_phase
    - line_cnt +1, saturating at all-ones
    - out_beats ← beat_cnt
  - if not line_had_data (blanking/porch line): phases and line_cnt unchanged.
  - In both cases: beat_cnt ← 0, line_had_data ← 0.
- Beat (in_valid, no line edge in the same cycle):
  - pix_phase ← (pix_phase + 2) mod 3
  - beat_cnt +1, saturating
  - line_had_data ← 1
- Line edge and in_valid in the same cycle: the line edge takes effect, the beat is dropped from phase and counts, and out_err is set.
- Select outputs:
  - DES: out_sel_even = pix_phase, out_sel_odd = (pix_phase + 1) mod 3
  - mono/reserved: both = 3
  - Phase registers stay in 0..2; all mod-3 arithmetic uses compare-and-subtract, no divider.
- The output logic ignores cfg_* changes mid-frame. Shadows update only at frame start.

## Timing
- Reset values:
  - out_sel_even = out_sel_odd = 3
  - out_frame_start = 0, out_lines = 0, out_beats = 0, out_err = 0
  - hs_last = 0
  - mode shadow = mono, phases 0, counters 0
- out_sel_* come from registered state only, with no combinational path from in_valid. The codes present in the cycle in_valid is high apply to that beat; the phase advances at that clock edge.
- out_frame_start asserts the cycle after the sampling edge that detects the frame start.
- Status outputs update on the clock edge that processes the line edge.
- Reset mid-line: everything returns to reset values. The first hsync rising edge after reset is detected normally (hs_last = 0). If in_hsync is already high when reset releases, a line edge is seen on the first clock.

## Test plan
- Reset then idle: out_sel_even = out_sel_odd = 3, out_err = 0, out_lines = 0.
- DES, x_offset 0, y_offset 1; frame start, then 4 beats on line 0:
  - even sels 0, 2, 1, 0; odd sels 1, 0, 2, 1
  - next active line starts with even sel 1.
- DES; frame start, then 2 hsync lines with no valid, then data: first active beat even sel = x_offset, so blanking lines do not advance the phase.
- Frame with 5 active lines of 7 beats each, then next frame start:
  - out_lines = 5 and out_frame_start is one cycle high
  - out_beats = 7 after each line edge.
- Change cfg_mode from mono to DES mid-frame: sels stay 3 until the next frame start, then follow DES phases.
- Drive in_valid high on the same cycle as an hsync rising edge: out_err = 1, beat_cnt is not incremented, the phase is unchanged by the beat, and out_err stays 1 until rstn is asserted.

Source files
------------

// File: rtl/vin_cfa_sequencer.sv
// Pixel-phase sequencer for the video-input colour path: tracks line/beat
// position from the sync/valid stream and drives per-beat colour-select codes.
module vin_cfa_sequencer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       cfg_mode,
  input  logic [1:0]       cfg_x_offset,
  input  logic [1:0]       cfg_y_offset,
  input  logic             in_vsync,
  input  logic             in_hsync,
  input  logic             in_valid,
  output logic [1:0]       out_sel_even,
  output logic [1:0]       out_sel_odd,
  output logic             out_frame_start,
  output logic [CNT_W-1:0] out_lines,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Phase values stay in 0..2, so one compare-and-subtract suffices.
  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end else begin
      s = s;
    end
    return s[1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             hs_last_r;
  logic             des_r, des_nxt_s;
  logic [1:0]       y_inc_r, y_inc_nxt_s;
  logic [1:0]       line_phase_r, line_phase_nxt_s;
  logic [1:0]       pix_phase_r, pix_phase_nxt_s;
  logic [CNT_W-1:0] line_cnt_r, line_cnt_nxt_s;
  logic [CNT_W-1:0] beat_cnt_r, beat_cnt_nxt_s;
  logic             had_data_r, had_data_nxt_s;
  logic [CNT_W-1:0] lines_nxt_s, beats_nxt_s;
  logic [1:0]       sel_even_nxt_s, sel_odd_nxt_s;
  logic             line_edge_s, frame_start_s, beat_s;

  assign line_edge_s   = in_hsync & ~hs_last_r;
  assign frame_start_s = line_edge_s & in_vsync;
  assign beat_s        = in_valid & ~line_edge_s;

  // Next-state for shadows, phases, counters and statistics.
  always_comb begin
    des_nxt_s        = des_r;
    y_inc_nxt_s      = y_inc_r;
    line_phase_nxt_s = line_phase_r;
    pix_phase_nxt_s  = pix_phase_r;
    line_cnt_nxt_s   = line_cnt_r;
    beat_cnt_nxt_s   = beat_cnt_r;
    had_data_nxt_s   = had_data_r;
    lines_nxt_s      = out_lines;
    beats_nxt_s      = out_beats;
    if (frame_start_s) begin
      des_nxt_s        = (cfg_mode == 2'd1);
      y_inc_nxt_s      = (cfg_y_offset == 2'd3) ? 2'd1 : cfg_y_offset;
      line_phase_nxt_s = (cfg_x_offset == 2'd3) ? 2'd0 : cfg_x_offset;
      pix_phase_nxt_s  = (cfg_x_offset == 2'd3) ? 2'd0 : cfg_x_offset;
      lines_nxt_s      = line_cnt_r;
      line_cnt_nxt_s   = {CNT_W{1'b0}};
      beat_cnt_nxt_s   = {CNT_W{1'b0}};
      had_data_nxt_s   = 1'b0;
    end else if (line_edge_s) begin
      // Blanking/porch lines leave phase and line count untouched.
      if (had_data_r) begin
        line_phase_nxt_s = mod3_add(line_phase_r, y_inc_r);
        pix_phase_nxt_s  = mod3_add(line_phase_r, y_inc_r);
        line_cnt_nxt_s   = sat_inc(line_cnt_r);
        beats_nxt_s      = beat_cnt_r;
      end else begin
        line_cnt_nxt_s   = line_cnt_r;
      end
      beat_cnt_nxt_s = {CNT_W{1'b0}};
      had_data_nxt_s = 1'b0;
    end else if (beat_s) begin
      pix_phase_nxt_s = mod3_add(pix_phase_r, 2'd2);
      beat_cnt_nxt_s  = sat_inc(beat_cnt_r);
      had_data_nxt_s  = 1'b1;
    end else begin
      had_data_nxt_s = had_data_r;
    end
  end

  // Select codes are registered from the next phase so they line up with the beat.
  always_comb begin
    sel_even_nxt_s = 2'd3;
    sel_odd_nxt_s  = 2'd3;
    if (des_nxt_s) begin
      sel_even_nxt_s = pix_phase_nxt_s;
      sel_odd_nxt_s  = mod3_add(pix_phase_nxt_s, 2'd1);
    end else begin
      sel_even_nxt_s = 2'd3;
      sel_odd_nxt_s  = 2'd3;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_last_r       <= 1'b0;
      des_r           <= 1'b0;
      y_inc_r         <= 2'd1;
      line_phase_r    <= 2'd0;
      pix_phase_r     <= 2'd0;
      line_cnt_r      <= {CNT_W{1'b0}};
      beat_cnt_r      <= {CNT_W{1'b0}};
      had_data_r      <= 1'b0;
      out_sel_even    <= 2'd3;
      out_sel_odd     <= 2'd3;
      out_frame_start <= 1'b0;
      out_lines       <= {CNT_W{1'b0}};
      out_beats       <= {CNT_W{1'b0}};
      out_err         <= 1'b0;
    end else begin
      hs_last_r       <= in_hsync;
      des_r           <= des_nxt_s;
      y_inc_r         <= y_inc_nxt_s;
      line_phase_r    <= line_phase_nxt_s;
      pix_phase_r     <= pix_phase_nxt_s;
      line_cnt_r      <= line_cnt_nxt_s;
      beat_cnt_r      <= beat_cnt_nxt_s;
      had_data_r      <= had_data_nxt_s;
      out_sel_even    <= sel_even_nxt_s;
      out_sel_odd     <= sel_odd_nxt_s;
      out_frame_start <= frame_start_s;
      out_lines       <= lines_nxt_s;
      out_beats       <= beats_nxt_s;
      out_err         <= out_err | (line_edge_s & in_valid);
    end
  end

endmodule

// File: tb/tb_vin_cfa_sequencer.sv
// Self-checking bench for vin_cfa_sequencer: directed test-plan steps plus
// randomized frames compared against a cycle-level reference model.
module tb_vin_cfa_sequencer;
  localparam int CNT_W = 12;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0]       cfg_mode, cfg_x_offset, cfg_y_offset;
  logic             in_vsync, in_hsync, in_valid;
  logic [1:0]       out_sel_even, out_sel_odd;
  logic             out_frame_start;
  logic [CNT_W-1:0] out_lines, out_beats;
  logic             out_err;

  vin_cfa_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .cfg_mode(cfg_mode), .cfg_x_offset(cfg_x_offset),
    .cfg_y_offset(cfg_y_offset), .in_vsync(in_vsync), .in_hsync(in_hsync),
    .in_valid(in_valid), .out_sel_even(out_sel_even), .out_sel_odd(out_sel_odd),
    .out_frame_start(out_frame_start), .out_lines(out_lines),
    .out_beats(out_beats), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  string tag = "reset";

  // Reference model state
  int m_des, m_yinc, m_lph, m_pph, m_lcnt, m_bcnt, m_had;
  int m_lines, m_beats, m_err, m_fs, m_hs;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_des = 0; m_yinc = 1; m_lph = 0; m_pph = 0; m_lcnt = 0; m_bcnt = 0;
    m_had = 0; m_lines = 0; m_beats = 0; m_err = 0; m_fs = 0; m_hs = 0;
  endtask

  task automatic model_step(input bit vs, input bit hs, input bit v);
    bit edge_seen;
    edge_seen = hs && !m_hs;
    m_fs = (edge_seen && vs) ? 1 : 0;
    if (edge_seen && v) m_err = 1;
    if (edge_seen && vs) begin
      m_des  = (cfg_mode == 2'd1) ? 1 : 0;
      m_lph  = (cfg_x_offset >= 2'd3) ? 0 : int'(cfg_x_offset);
      m_pph  = m_lph;
      m_yinc = (cfg_y_offset >= 2'd3) ? 1 : int'(cfg_y_offset);
      m_lines = m_lcnt; m_lcnt = 0; m_bcnt = 0; m_had = 0;
    end else if (edge_seen) begin
      if (m_had != 0) begin
        m_lph = (m_lph + m_yinc) % 3;
        m_pph = m_lph;
        m_lcnt = (m_lcnt == CMAX) ? CMAX : m_lcnt + 1;
        m_beats = m_bcnt;
      end
      m_bcnt = 0; m_had = 0;
    end else if (v) begin
      m_pph = (m_pph + 2) % 3;
      m_bcnt = (m_bcnt == CMAX) ? CMAX : m_bcnt + 1;
      m_had = 1;
    end
    m_hs = hs ? 1 : 0;
  endtask

  task automatic check_all();
    chk({tag, ".sel_even"}, 32'(out_sel_even), (m_des != 0) ? m_pph : 3);
    chk({tag, ".sel_odd"},  32'(out_sel_odd),  (m_des != 0) ? (m_pph + 1) % 3 : 3);
    chk({tag, ".frame_start"}, 32'(out_frame_start), m_fs);
    chk({tag, ".lines"}, 32'(out_lines), m_lines);
    chk({tag, ".beats"}, 32'(out_beats), m_beats);
    chk({tag, ".err"}, 32'(out_err), m_err);
  endtask

  // One clock: check the current outputs, then drive inputs for the next edge.
  task automatic cyc(input bit vs, input bit hs, input bit v);
    @(negedge clk);
    check_all();
    in_vsync = vs; in_hsync = hs; in_valid = v;
    model_step(vs, hs, v);
  endtask

  task automatic frame_start();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic line_edge();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input bit hs_level);
    @(negedge clk);
    rstn = 1'b0;
    in_vsync = hs_level; in_hsync = hs_level; in_valid = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rstn = 1'b1;
    model_step(hs_level, hs_level, 1'b0);
  endtask

  int e_even[4] = '{0, 2, 1, 0};
  int e_odd[4]  = '{1, 0, 2, 1};

  initial begin
    rstn = 1'b0;
    cfg_mode = 2'd0; cfg_x_offset = 2'd0; cfg_y_offset = 2'd1;
    in_vsync = 1'b0; in_hsync = 1'b0; in_valid = 1'b0;
    model_reset();
    #12;
    check_all();
    rstn = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("idle.sel_even", 32'(out_sel_even), 3);
    chk("idle.lines", 32'(out_lines), 0);

    // DES, x=0, y=1: four beats, then next line start
    tag = "des_basic";
    cfg_mode = 2'd1; cfg_x_offset = 2'd0; cfg_y_offset = 2'd1;
    frame_start();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("des_basic.even_dir", 32'(out_sel_even), e_even[i]);
      chk("des_basic.odd_dir", 32'(out_sel_odd), e_odd[i]);
    end
    line_edge();
    cyc(1'b0, 1'b0, 1'b1);
    chk("des_basic.line1_even", 32'(out_sel_even), 1);

    // Blanking lines must not advance the phase
    tag = "blanking";
    cfg_x_offset = 2'd2;
    frame_start();
    line_edge();
    line_edge();
    cyc(1'b0, 1'b0, 1'b1);
    chk("blanking.first_even", 32'(out_sel_even), 2);

    // Five lines of seven beats, then frame start
    tag = "stats";
    frame_start();
    for (int l = 0; l < 5; l++) begin
      beats(7);
      line_edge();
      chk("stats.beats_dir", 32'(out_beats), 7);
    end
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("stats.fs_high", 32'(out_frame_start), 1);
    chk("stats.lines_dir", 32'(out_lines), 5);
    cyc(1'b0, 1'b0, 1'b0);
    chk("stats.fs_low", 32'(out_frame_start), 0);

    // Mode change mid-frame is ignored until the next frame start
    tag = "shadow";
    cfg_mode = 2'd0;
    frame_start();
    beats(2);
    cfg_mode = 2'd1; cfg_x_offset = 2'd1;
    beats(2);
    chk("shadow.mono_even", 32'(out_sel_even), 3);
    line_edge();
    cyc(1'b0, 1'b0, 1'b1);
    chk("shadow.mono_odd", 32'(out_sel_odd), 3);
    frame_start();
    cyc(1'b0, 1'b0, 1'b1);
    chk("shadow.des_even", 32'(out_sel_even), 1);

    // Valid coinciding with hsync edge: beat dropped, sticky error
    tag = "collide";
    beats(2);
    line_edge();
    beats(3);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("collide.err", 32'(out_err), 1);
    chk("collide.beats_dir", 32'(out_beats), 3);
    beats(2);
    line_edge();
    chk("collide.next_beats", 32'(out_beats), 2);
    frame_start();
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    chk("collide.err_sticky", 32'(out_err), 1);
    tag = "reset2";
    do_reset(1'b0);
    chk("reset2.err_clear", 32'(out_err), 0);

    // hsync already high at reset release: edge seen on first clock
    tag = "reset_hs";
    cfg_mode = 2'd1; cfg_x_offset = 2'd2;
    do_reset(1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("reset_hs.fs", 32'(out_frame_start), 1);
    cyc(1'b0, 1'b0, 1'b0);

    // Randomized frames with reserved configs, collisions and gaps
    tag = "random";
    for (int f = 0; f < 12; f++) begin
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_x_offset = 2'($urandom_range(0, 3));
      cfg_y_offset = 2'($urandom_range(0, 3));
      frame_start();
      for (int l = 0; l < int'($urandom_range(0, 8)); l++) begin
        for (int b = 0; b < int'($urandom_range(0, 20)); b++) begin
          cyc(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0));
          if ($urandom_range(0, 15) == 0) begin
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_y_offset = 2'($urandom_range(0, 3));
          end
        end
        cyc(1'b0, 1'b1, 1'($urandom_range(0, 7) == 0));
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
      end
      if (f == 6) begin
        beats(3);
        do_reset(1'($urandom_range(0, 1)));
      end
    end
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
